// File: rtl/mips32_pkg.sv
// Shared constants for the MIPS32 core: opcodes, instruction classes and the
// program-loader frame format and FSM encoding.
package mips32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    INSN_R,
    INSN_I,
    INSN_J
  } insn_type_t;

  function automatic insn_type_t insn_type_of(input logic [5:0] opcode);
    if (opcode == OP_RTYPE) return INSN_R;
    if (opcode == OP_J || opcode == OP_JAL) return INSN_J;
    return INSN_I;
  endfunction

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [15:0] MAX_WORDS = 16'd1024;

  typedef enum logic [2:0] {
    IDLE,
    A_HI,
    A_LO,
    C_HI,
    C_LO,
    DATA,
    CSUM,
    FIN
  } ld_state_t;

endpackage

// File: rtl/word_packer.sv
// Packs accepted data bytes big-endian into 32-bit words and keeps the
// running XOR checksum of every data byte in the frame.
module word_packer
  import mips32_pkg::*;
(
  input  logic        clk1,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_last,
  output logic [7:0]  csum
);

  logic [23:0] shift;
  logic [1:0]  idx;

  always_ff @(posedge clk1) begin
    if (rst || clear) begin
      shift <= '0;
      idx   <= '0;
      csum  <= '0;
    end else if (byte_en) begin
      shift <= {shift[15:0], byte_in};
      idx   <= idx + 1'b1;
      csum  <= csum ^ byte_in;
    end
  end

  // The complete word includes the byte being accepted this cycle.
  assign word      = {shift, byte_in};
  assign word_last = (idx == 2'd3);

endmodule

// File: rtl/mem_prog_loader.sv
// Receives a framed program image over a byte stream and writes it into the
// instruction memory, holding the CPU until the frame finishes.
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_data must be stable while in_valid is high and not yet accepted.
module mem_prog_loader
  import mips32_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] SYNC   = SYNC_BYTE
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [2:0]        dbg_state
);

  ld_state_t         state, state_nx;
  logic              accept;
  logic [7:0]        hi_q;
  logic [15:0]       field16;
  logic [ADDR_W-1:0] addr;
  logic [10:0]       cnt;
  logic [31:0]       word;
  logic              word_last;
  logic [7:0]        csum;

  assign accept    = in_valid && in_ready;
  assign field16   = {hi_q, in_data};
  assign in_ready  = (state != FIN);
  assign cpu_hold  = (state != IDLE);
  assign done      = (state == FIN);
  assign dbg_state = state;

  word_packer u_packer (
    .clk1      (clk1),
    .rst       (rst),
    .clear     (accept && state == IDLE && in_data == SYNC),
    .byte_en   (accept && state == DATA),
    .byte_in   (in_data),
    .word      (word),
    .word_last (word_last),
    .csum      (csum)
  );

  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept && in_data == SYNC) state_nx = A_HI;
      A_HI: if (accept) state_nx = A_LO;
      A_LO: if (accept) state_nx = C_HI;
      C_HI: if (accept) state_nx = C_LO;
      C_LO: if (accept) begin
        if (field16 > MAX_WORDS)  state_nx = IDLE;
        else if (field16 == '0)   state_nx = CSUM;
        else                      state_nx = DATA;
      end
      DATA: if (accept && word_last && cnt == 11'd1) state_nx = CSUM;
      CSUM: if (accept) state_nx = (in_data == csum) ? FIN : IDLE;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address, count and memory-port registers; mem_we is a one-cycle strobe.
  always_ff @(posedge clk1) begin
    if (rst) begin
      hi_q      <= '0;
      addr      <= '0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: if (in_data == SYNC) error <= 1'b0;
          A_HI, C_HI: hi_q <= in_data;
          A_LO: addr <= field16[ADDR_W-1:0];
          C_LO: begin
            cnt <= field16[10:0];
            if (field16 > MAX_WORDS) error <= 1'b1;
          end
          DATA: if (word_last) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= word;
            addr      <= addr + 1'b1;
            cnt       <= cnt - 1'b1;
          end
          CSUM: if (in_data != csum) error <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_prog_loader.sv
// Directed bench for mem_prog_loader: a per-cycle vector table followed by
// hand-written multi-cycle sequences checked against an expected-write queue.
module tb_mem_prog_loader;
  import mips32_pkg::*;

  localparam int ADDR_W = 10;

  // clock / reset
  logic              clk1 = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [2:0]        dbg_state;

  always #5 clk1 = ~clk1;

  mem_prog_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              r;
    logic              v;
    logic [7:0]        d;
    logic              rdy;
    logic              hold;
    logic              we;
    logic              dn;
    logic              er;
    logic [ADDR_W-1:0] a;
    logic [31:0]       w;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic v, input logic [7:0] d,
                         input logic rdy, input logic hold, input logic we,
                         input logic dn, input logic er,
                         input logic [ADDR_W-1:0] a, input logic [31:0] w);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.rdy = rdy; t.hold = hold; t.we = we;
    t.dn = dn; t.er = er; t.a = a; t.w = w;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // driver: optional idle cycle, then hold the byte until it is accepted
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  // scoreboard: every mem_we must match the head of exp_q
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_w;
  bit                 sb_en = 1'b0;

  always @(negedge clk1) begin
    if (sb_en && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: addr=%0d data=%h required no write", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_w) begin
          errors++;
          $display("FAIL wr_data: got addr=%0d data=%h required addr=%0d data=%h",
                   mem_addr, mem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
        end
      end
    end
  end

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    // r v data  rdy hold we done err addr wdata
    add_vec(1, 0, 8'h00, 1, 0, 0, 0, 0, 0,  0);   // reset state
    add_vec(0, 1, 8'h3C, 1, 0, 0, 0, 0, 0,  0);   // non-SYNC in IDLE discarded
    add_vec(0, 1, 8'hA5, 1, 1, 0, 0, 0, 0,  0);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 0,  0);
    add_vec(0, 0, 8'h00, 1, 1, 0, 0, 0, 0,  0);   // stall
    add_vec(0, 1, 8'h10, 1, 1, 0, 0, 0, 0,  0);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 0,  0);
    add_vec(0, 1, 8'h01, 1, 1, 0, 0, 0, 0,  0);
    add_vec(0, 1, 8'hDE, 1, 1, 0, 0, 0, 0,  0);
    add_vec(0, 1, 8'hAD, 1, 1, 0, 0, 0, 0,  0);
    add_vec(0, 1, 8'hBE, 1, 1, 0, 0, 0, 0,  0);
    add_vec(0, 1, 8'hEF, 1, 1, 1, 0, 0, 16, DB);  // word written at 16
    add_vec(0, 1, 8'h22, 0, 1, 0, 1, 0, 16, DB);  // FIN: done, not ready
    add_vec(0, 0, 8'h00, 1, 0, 0, 0, 0, 16, DB);
    // same frame, bad checksum 23
    add_vec(0, 1, 8'hA5, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h10, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h01, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'hDE, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'hAD, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'hBE, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'hEF, 1, 1, 1, 0, 0, 16, DB);
    add_vec(0, 1, 8'h23, 1, 0, 0, 0, 1, 16, DB);  // error, no done
    add_vec(0, 0, 8'h00, 1, 0, 0, 0, 1, 16, DB);  // error sticky
    // count 0 frame clears error
    add_vec(0, 1, 8'hA5, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 0, 1, 0, 1, 0, 16, DB);  // FIN
    add_vec(0, 1, 8'hA5, 1, 0, 0, 0, 0, 16, DB);  // byte offered in FIN not taken
    // count 0x0401 exceeds limit
    add_vec(0, 1, 8'hA5, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h00, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h04, 1, 1, 0, 0, 0, 16, DB);
    add_vec(0, 1, 8'h01, 1, 0, 0, 0, 1, 16, DB);
    add_vec(0, 1, 8'h00, 1, 0, 0, 0, 1, 16, DB);

    foreach (vecs[i]) begin
      rst      = vecs[i].r;
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      tick();
      check($sformatf("vec%0d", i),
            64'({in_ready, cpu_hold, mem_we, done, error, mem_addr, mem_wdata}),
            64'({vecs[i].rdy, vecs[i].hold, vecs[i].we, vecs[i].dn, vecs[i].er,
                 vecs[i].a, vecs[i].w}));
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    // address wrap 1023 -> 0 with a gap before every other byte; the data
    // bytes XOR to 00, so the trailing 33 is a checksum error after both writes
    sb_en = 1'b1;
    exp_q.push_back({10'd1023, 32'h11111111});
    exp_q.push_back({10'd0,    32'h22222222});
    begin
      logic [7:0] fr [14];
      fr = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h11, 8'h11,
             8'h22, 8'h22, 8'h22, 8'h22, 8'h33};
      for (int i = 0; i < 14; i++) send_byte(fr[i], (i % 2) == 1);
    end
    check("wrap_err_done", 64'({error, done, cpu_hold}), 64'({1'b1, 1'b0, 1'b0}));
    check("wrap_last_word", 64'({mem_addr, mem_wdata}), 64'({10'd0, 32'h22222222}));
    tick();
    check("wrap_q_empty", 64'(exp_q.size()), 64'd0);

    // reset after two data bytes, then a clean frame
    begin
      logic [7:0] fr [7];
      fr = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h02, 8'h01, 8'h02};
      for (int i = 0; i < 7; i++) send_byte(fr[i], (i % 2) == 0);
    end
    in_valid = 1'b1;
    in_data  = 8'h03;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_outputs",
          64'({in_ready, cpu_hold, mem_we, done, error, mem_addr, mem_wdata}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0}));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    exp_q.push_back({10'd32, 32'h11223344});
    begin
      logic [7:0] fr [10];
      fr = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      for (int i = 0; i < 10; i++) send_byte(fr[i], (i % 2) == 1);
    end
    check("after_rst_fin", 64'({in_ready, done, error, cpu_hold}),
          64'({1'b0, 1'b1, 1'b0, 1'b1}));
    tick();
    check("after_rst_idle", 64'({in_ready, done, error, cpu_hold}),
          64'({1'b1, 1'b0, 1'b0, 1'b0}));
    check("after_rst_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_prog_loader.md
MEM_PROG_LOADER -- requirements
Module: mem_prog_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, the word-address width of the 1024 x 32 memory.
REQ-002 The block SHALL have parameter SYNC, default 8'hA5, the frame header byte.
REQ-003 clk1  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  8  program byte stream.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  the block accepts a byte; a byte transfers when in_valid and in_ready are both high.
REQ-008 mem_we  output  1  memory write strobe, one cycle per word.
REQ-009 mem_addr  output  ADDR_W  memory word address.
REQ-010 mem_wdata  output  32  memory write data.
REQ-011 cpu_hold  output  1  holds the pipeline halted while a frame is in progress.
REQ-012 done  output  1  one-cycle pulse when a frame completes with a good checksum.
REQ-013 error  output  1  sticky frame-error flag.

Function
REQ-014 Frame format SHALL be SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, CNT x 4 data bytes, then CSUM.
- Address and count are 16-bit big-endian.
- The address uses its low ADDR_W bits.
REQ-015 The FSM states SHALL be IDLE, A_HI, A_LO, C_HI, C_LO, DATA, CSUM and FIN, advancing only on an accepted byte, except FIN.
REQ-016 In IDLE, any byte other than SYNC SHALL be discarded with no state change.
REQ-017 Accepting SYNC in IDLE SHALL clear error and the checksum, then enter A_HI.
REQ-018 in_ready SHALL be high in every state except FIN.
REQ-019 cpu_hold SHALL be high in every state except IDLE.
REQ-020 In C_LO, a count above 1024 SHALL set error and return to IDLE.
REQ-021 In C_LO, a count of 0 SHALL go to CSUM; any other legal count SHALL go to DATA.
REQ-022 Data bytes SHALL pack big-endian: the first byte lands in [31:24] and the fourth in [7:0].
REQ-023 The cycle after the fourth byte of a word is accepted, mem_we SHALL be 1, with mem_addr at the current address and mem_wdata at the packed word.
REQ-024 After each word, the address SHALL increment modulo 2^ADDR_W (1023 wraps to 0) and the remaining count SHALL decrement.
REQ-025 When the last word is accepted, the FSM SHALL go to CSUM.
REQ-026 The checksum SHALL be the 8-bit XOR of all data bytes only.
REQ-027 In CSUM, if the received byte equals the checksum the FSM SHALL go to FIN; otherwise it SHALL set error and go to IDLE.
REQ-028 Memory words already written before a checksum error SHALL NOT be rolled back.
REQ-029 FIN SHALL last exactly one cycle: done=1, in_ready=0, then IDLE.
REQ-030 mem_we SHALL be 0 except in the cycles defined in REQ-023.
REQ-031 A stall on in_valid SHALL leave all state unchanged.
REQ-032 A SYNC byte received mid-frame SHALL be treated as ordinary frame content, with no resynchronisation.

Reset
REQ-033 When rst is high at a clock edge, the following SHALL take effect on that edge, overriding any handshake in progress:
- state=IDLE;
- mem_we=0, mem_addr=0, mem_wdata=0;
- done=0, error=0, cpu_hold=0;
- checksum, count and byte index cleared;
- in_ready=1.
REQ-034 Reset mid-frame SHALL abandon the frame; the next frame SHALL be accepted normally.

Structure
REQ-035 SYNC, the state encoding and the 1024-word count limit SHALL live in the shared package mips32_pkg, alongside the opcode and type constants.
REQ-036 Byte-to-word packing, the byte index and the XOR checksum SHALL form one sub-module, word_packer; the FSM and address/count logic stay in mem_prog_loader.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Frame A5 00 10 00 01 DE AD BE EF 22 -> one mem_we with addr 16 and data 32'hDEADBEEF; done pulses 1 cycle; error=0.
- Frame A5 03 FF 00 02 with data 11111111, 22222222 and CSUM 33 -> writes at addr 1023 then 0.
- A frame with count 0 and CSUM 00 -> no mem_we; done pulses.
- A frame with a bad CSUM (e.g. 23 instead of 22 for the first scenario) -> the word is written, error=1, done=0; the next good frame clears error.
- A frame with count 16'h0401 -> error=1 after CNT_LO; no mem_we.
- in_valid toggling every other cycle plus rst asserted after 2 data bytes -> clean abort; a following frame loads correctly.
